data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder end of the data SRAM interface that the EX stage drives (`data_sram_en/wen/addr/wdata`). It holds the on-chip data memory, performs byte-masked writes, and returns read data one cycle after a read is accepted, for the MEM stage to consume. A parameterised read latency lets the bench and FPGA builds model slower memory. When the latency exceeds one cycle, the block raises a stall request into the existing stall controller.

## Interface
- `ADDR_W`, default 12: word-index width; memory is 2^ADDR_W 32-bit words (16 KB by default).
- `LAT`, default 1: read latency in cycles, counted from first presentation of the read to `data_sram_rdata` being valid; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_sram_en`  in  1  request valid.
- `data_sram_wen`  in  4  byte write enables; 4'b0000 with `en`=1 is a read.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data, byte lane i = bits [8i+7:8i].
- `data_sram_rdata`  out  32  read data, registered.
- `rdata_valid`  out  1  one-cycle pulse; `data_sram_rdata` holds a newly completed read.
- `stallreq_for_mem`  out  1  combinational stall request to the stall controller.

## Operation
- Word index is `addr[ADDR_W+1:2]`.
  - `addr[1:0]` is ignored; alignment is the EX stage's responsibility.
  - Address bits above `ADDR_W+1` are ignored, so the memory aliases.
- Write (`en`=1, `wen`≠0):
  - Accepted in the same cycle in any state, with no stall.
  - At the clock edge, each byte lane i with `wen[i]`=1 is written; other lanes keep their value.
  - A write does not change `data_sram_rdata` or `rdata_valid`.
- Read (`en`=1, `wen`=0): requires the requester to hold `en/wen/addr` stable while `stallreq_for_mem`=1. This is satisfied because the stall freezes the EX register.
- State machine, two states, IDLE and WAIT, with counter `cnt` (3 bits):
  - IDLE, read presented, `LAT`=1: read accepted at this edge; stay in IDLE; `stallreq_for_mem`=0.
  - IDLE, read presented, `LAT`>1: `stallreq_for_mem`=1; go to WAIT with `cnt`=`LAT`-2; array not read.
  - WAIT, `en`=1 and `wen`=0, `cnt`≠0: `stallreq_for_mem`=1; `cnt` decrements.
  - WAIT, `en`=1 and `wen`=0, `cnt`=0: `stallreq_for_mem`=0; read accepted at this edge; go to IDLE.
  - WAIT, `en`=0 (flush removed the request): abort to IDLE; `stallreq_for_mem`=0; no read is performed and no `rdata_valid` pulse is produced.
  - WAIT, `en`=1 and `wen`≠0: not legal under the hold rule. Required response: perform the write and abort to IDLE as for `en`=0.
- Accepted read: at the accepting edge, `data_sram_rdata` ← memory word and `rdata_valid` ← 1. Otherwise `rdata_valid` ← 0 and `data_sram_rdata` holds its value.
- Read-after-write: a write at edge N is visible to a read accepted at edge N+1 or later. Reads and writes never coincide, because the port is single.
- Memory contents are not reset; simulation starts with X unless preloaded.

## Timing
- Reset values: `data_sram_rdata`=0, `rdata_valid`=0, state IDLE, `cnt`=0.
  - Because `stallreq_for_mem` is combinational, it is 0 whenever `resetn`=0.
  - Reset asserted during WAIT returns the block to IDLE immediately and drops the stall in the same cycle.
- Read first presented in cycle T:
  - `stallreq_for_mem`=1 in cycles T..T+LAT-2.
  - Accepted at the end of cycle T+LAT-1.
  - `rdata_valid`=1 and data valid in cycle T+LAT.
- `LAT`=1: zero stall cycles; back-to-back reads give `rdata_valid`=1 in consecutive cycles.
- The read in cycle T+LAT-1 is accepted exactly once. The held request advances with the pipeline on that edge, so no duplicate read occurs.
- Combinational path: `data_sram_en/wen` plus state → `stallreq_for_mem`.

## Test plan
- Reset: hold `resetn`=0 with `en`=1, `wen`=0 → `stallreq_for_mem`=0, `rdata_valid`=0, `data_sram_rdata`=0.
- Byte write merge, `LAT`=1:
  - Write 32'h11223344 to addr 0x40 with `wen`=4'hF.
  - Then write 32'hAABBCCDD to addr 0x40 with `wen`=4'b0101.
  - Then read 0x40 → next cycle `rdata_valid`=1, `data_sram_rdata`=32'h11BB33DD.
- Back-to-back reads, `LAT`=1: reads of 0x0, 0x4, 0x8 in consecutive cycles → three consecutive `rdata_valid` pulses with the matching words; `stallreq_for_mem` stays 0.
- Latency, `LAT`=4: read 0x40 held in cycle T → `stallreq_for_mem`=1 in cycles T..T+2 and 0 in T+3; `rdata_valid`=1 in cycle T+4 only, with 32'h11BB33DD.
- Flush abort, `LAT`=4: read presented in T; `en`=0 in T+1 → `stallreq_for_mem`=0 in T+1; no `rdata_valid` pulse follows; `data_sram_rdata` unchanged.
- Async reset mid-WAIT, `LAT`=4: drop `resetn` in cycle T+1 → stall deasserts without waiting for a clock edge. After release, a new read of 0x0 again sees exactly 3 stall cycles.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder end of the EX-stage data SRAM port.
// Holds the data memory, performs byte-masked writes and returns read data
// LAT cycles after a read is first presented, stalling the pipeline while
// a multi-cycle read is in flight.
//
// Handshake: a request is valid when data_sram_en=1. A write is taken on the
// edge it is presented. A read is taken on the edge where
// stallreq_for_mem=0. The requester keeps en/wen/addr stable for as long as
// stallreq_for_mem=1. The result appears one cycle after that edge, as a
// single-cycle rdata_valid pulse with data_sram_rdata.
module data_sram_resp #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq_for_mem
);

  localparam int DEPTH = 1 << ADDR_W;

  // LAT is expected in 1..8. Any LAT above 1 takes the waiting path.
  localparam bit         MULTI    = (LAT > 1);
  localparam logic [2:0] CNT_LOAD = MULTI ? 3'(LAT - 2) : 3'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // state and cnt are kept as plain named signals so checkers can bind to them.
  state_t      state;
  logic [2:0]  cnt;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              is_read;
  logic              is_write;
  logic              read_accept;
  logic              unused_addr;

  // Only the word-index bits select a word. The byte offset and the upper
  // bits are ignored, so the memory aliases across the address space.
  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign is_read  = data_sram_en && (data_sram_wen == 4'b0000);
  assign is_write = data_sram_en && (data_sram_wen != 4'b0000);

  // A read is taken either straight from IDLE (single-cycle memory) or on
  // the last WAIT cycle, once the counter has run out.
  always_comb begin
    read_accept = 1'b0;
    if (resetn && is_read) begin
      if (state == IDLE) read_accept = !MULTI;
      else               read_accept = (cnt == 3'd0);
    end
  end

  // The stall request is combinational so that the EX register freezes in
  // the same cycle the read is first seen. It is forced low while in reset.
  always_comb begin
    stallreq_for_mem = 1'b0;
    if (resetn && is_read) begin
      if (state == IDLE) stallreq_for_mem = MULTI;
      else               stallreq_for_mem = (cnt != 3'd0);
    end
  end

  // Read-latency FSM. If en drops, or a write shows up, while in WAIT, the
  // read was flushed, so return to IDLE without producing a result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= read_accept;
      case (state)
        IDLE: begin
          if (is_read && MULTI) begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (!is_read) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Read data register: it loads only on an accepted read and otherwise
  // holds its value, so writes never disturb it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= 32'd0;
    end else if (read_accept) begin
      data_sram_rdata <= mem[idx];
    end
  end

  // Byte-masked write port. Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (resetn && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp. Two instances are used: index 0 with LAT=1
// and index 1 with LAT=4. A word-level memory model predicts read data.
// A scoreboard of expected words and expected valid cycles is checked by a
// monitor on the falling edge.
module tb_data_sram_resp;

  localparam int ADDR_W = 12;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [1:0]  en;
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  valid;
  logic [1:0]  stall;

  data_sram_resp #(.ADDR_W(ADDR_W), .LAT(LAT_A)) dut_a (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en[0]),
    .data_sram_wen    (wen[0]),
    .data_sram_addr   (addr[0]),
    .data_sram_wdata  (wdata[0]),
    .data_sram_rdata  (rdata[0]),
    .rdata_valid      (valid[0]),
    .stallreq_for_mem (stall[0])
  );

  data_sram_resp #(.ADDR_W(ADDR_W), .LAT(LAT_B)) dut_b (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en[1]),
    .data_sram_wen    (wen[1]),
    .data_sram_addr   (addr[1]),
    .data_sram_wdata  (wdata[1]),
    .data_sram_rdata  (rdata[1]),
    .rdata_valid      (valid[1]),
    .stallreq_for_mem (stall[1])
  );

  // ---------------- bookkeeping / model ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat [2];

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          due_q0 [$];
  int          due_q1 [$];

  logic [31:0] mem_m [int];       // keyed by instance and word index
  logic [31:0] last_rdata [2];    // value data_sram_rdata should be holding

  logic [31:0] mon_d;
  int          mon_due;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int key(input int i, input logic [31:0] a);
    return i * (1 << ADDR_W) + int'(a[ADDR_W+1:2]);
  endfunction

  // Expected result is due on the cycle after the accepting edge.
  task automatic push_exp(input int i, input logic [31:0] d);
    if (i == 0) begin
      exp_q0.push_back(d);
      due_q0.push_back(cyc + 1);
    end else begin
      exp_q1.push_back(d);
      due_q1.push_back(cyc + 1);
    end
    last_rdata[i] = d;
  endtask

  task automatic model_write(input int i, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] w);
    logic [31:0] word;
    int k;
    k = key(i, a);
    word = mem_m.exists(k) ? mem_m[k] : 32'hxxxx_xxxx;
    for (int b = 0; b < 4; b++) begin
      if (w[b]) word[8*b +: 8] = d[8*b +: 8];
    end
    mem_m[k] = word;
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] w);
    en[i] = 1'b1; wen[i] = w; addr[i] = a; wdata[i] = d;
    @(negedge clk);
    chk($sformatf("wr_stall_%0d", i), {31'd0, stall[i]}, 32'd0);
    @(posedge clk);
    model_write(i, a, d, w);
    #1;
    en[i] = 1'b0; wen[i] = 4'd0;
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input bit hold);
    int stalls;
    bit done;
    stalls = 0;
    done = 1'b0;
    en[i] = 1'b1; wen[i] = 4'd0; addr[i] = a;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (stall[i]) begin
        stalls++;
      end else begin
        push_exp(i, mem_m[key(i, a)]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout_%0d: got no accept expected accept within 12 cycles", i);
    end
    chk($sformatf("rd_stall_cycles_%0d", i), stalls, lat[i] - 1);
    if (!hold) en[i] = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i] === 1'b1) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL stray_valid_%0d: got rdata_valid=1 expected 0 (cyc %0d)", i, cyc);
        end else begin
          if (i == 0) begin
            mon_d = exp_q0.pop_front();
            mon_due = due_q0.pop_front();
          end else begin
            mon_d = exp_q1.pop_front();
            mon_due = due_q1.pop_front();
          end
          chk($sformatf("rdata_%0d", i), rdata[i], mon_d);
          chk($sformatf("valid_cycle_%0d", i), cyc, mon_due);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          idx_list [$];
  logic [31:0] a, d;
  logic [3:0]  w;
  int          pick;

  initial begin
    lat[0] = LAT_A;
    lat[1] = LAT_B;
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    resetn = 1'b0;
    en = 2'b11;
    for (int i = 0; i < 2; i++) begin
      wen[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end

    // Reset with a read held: no stall, no valid, zero data.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_stall_%0d", i), {31'd0, stall[i]}, 32'd0);
      chk($sformatf("rst_valid_%0d", i), {31'd0, valid[i]}, 32'd0);
      chk($sformatf("rst_rdata_%0d", i), rdata[i], 32'd0);
    end
    en = 2'b00;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Byte merge and read-after-write on both instances.
    for (int i = 0; i < 2; i++) begin
      do_write(i, 32'h40, 32'h1122_3344, 4'hF);
      do_write(i, 32'h40, 32'hAABB_CCDD, 4'b0101);
      do_write(i, 32'h0, 32'h0BAD_F00D, 4'hF);
      do_write(i, 32'h4, 32'h1357_9BDF, 4'hF);
      do_write(i, 32'h8, 32'h2468_ACE0, 4'hF);
      do_read(i, 32'h40, 1'b0);
    end

    // Back-to-back reads with single-cycle latency.
    do_read(0, 32'h0, 1'b1);
    do_read(0, 32'h4, 1'b1);
    do_read(0, 32'h8, 1'b0);
    @(posedge clk); #1;

    // Flush abort while waiting: stall drops, no result, data held.
    en[1] = 1'b1; wen[1] = 4'd0; addr[1] = 32'h40;
    @(negedge clk);
    chk("flush_stall_t0", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    en[1] = 1'b0;
    @(negedge clk);
    chk("flush_stall_t1", {31'd0, stall[1]}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("flush_rdata_held", rdata[1], last_rdata[1]);

    // A write that replaces a waiting read: written, no stall, read dropped.
    en[1] = 1'b1; wen[1] = 4'd0; addr[1] = 32'h40;
    @(negedge clk);
    chk("wwait_stall_t0", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    do_write(1, 32'h80, 32'hCAFE_BABE, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("wwait_rdata_held", rdata[1], last_rdata[1]);
    do_read(1, 32'h80, 1'b0);

    // Asynchronous reset during WAIT drops the stall before any edge.
    en[1] = 1'b1; wen[1] = 4'd0; addr[1] = 32'h0;
    @(negedge clk);
    chk("areset_stall_t0", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    chk("areset_stall_t1", {31'd0, stall[1]}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_stall_drop", {31'd0, stall[1]}, 32'd0);
    chk("areset_rdata", rdata[1], 32'd0);
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    en[1] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    do_read(1, 32'h0, 1'b0);

    // Randomized traffic: aliased addresses, partial writes, random gaps.
    for (int i = 0; i < 2; i++) begin
      idx_list.delete();
      while (idx_list.size() < 16) begin
        pick = $urandom_range(0, (1 << ADDR_W) - 1);
        if (!mem_m.exists(i * (1 << ADDR_W) + pick)) begin
          idx_list.push_back(pick);
          a = $urandom;
          a[ADDR_W+1:2] = pick[ADDR_W-1:0];
          do_write(i, a, $urandom, 4'hF);
        end
      end
      for (int n = 0; n < 40; n++) begin
        pick = idx_list[$urandom_range(0, idx_list.size() - 1)];
        a = $urandom;
        a[ADDR_W+1:2] = pick[ADDR_W-1:0];
        if ($urandom_range(0, 2) == 0) begin
          d = $urandom;
          w = 4'($urandom_range(1, 15));
          do_write(i, a, d, w);
        end else begin
          do_read(i, a, $urandom_range(0, 1) == 1);
        end
        if ($urandom_range(0, 1) == 1) begin
          en[i] = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
      en[i] = 1'b0;
      @(posedge clk); #1;
    end

    repeat (6) @(posedge clk);
    #1;
    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q1_drained", exp_q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck run still reports.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
